// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : XLEN x NREGS register file, 2R/1W, with pending-write
//              scoreboard and post-reset zeroing. Option: REGFILE_SB_BYPASS_EN
// Rev 1.0
// ============================================================================
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_done,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_wa,
    output logic            iss_ready,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [AW-1:0] C_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] C_ZERO = '0;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    state_t           r_state;
    logic [AW-1:0]    r_cnt;
    logic             r_init_done;
    logic             w_wr_en;
    logic             w_fire;

    assign init_done = r_init_done;
    assign w_wr_en   = r_init_done && we && (wa != C_ZERO);
    assign w_fire    = iss_valid && iss_ready && (iss_wa != C_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= INIT;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Set is applied after clear so a same-cycle issue wins over writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            if (w_wr_en) begin
                r_pending[wa] <= 1'b0;
            end
            if (w_fire) begin
                r_pending[iss_wa] <= 1'b1;
            end
        end
    end

    // Storage has no reset; the sequencer clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (r_init_done) begin
            if (ra1 != C_ZERO) begin
                rd1   = r_regs[ra1];
                busy1 = r_pending[ra1];
`ifdef REGFILE_SB_BYPASS_EN
                if (w_wr_en && (wa == ra1)) begin
                    rd1   = wd;
                    busy1 = 1'b0;
                end
`endif
            end
            if (ra2 != C_ZERO) begin
                rd2   = r_regs[ra2];
                busy2 = r_pending[ra2];
`ifdef REGFILE_SB_BYPASS_EN
                if (w_wr_en && (wa == ra2)) begin
                    rd2   = wd;
                    busy2 = 1'b0;
                end
`endif
            end
        end
    end

    always_comb begin
        iss_ready = r_init_done && ((iss_wa == C_ZERO) || !r_pending[iss_wa]);
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr_en && (wa == iss_wa)) begin
            iss_ready = 1'b1;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : directed, table-driven bench for regfile_sb
// Rev 1.0
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        busy1, busy2;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic        iss_ready;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        iss_valid;
        logic [4:0]  iss_wa;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [19];

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .busy1     (busy1),
        .busy2     (busy2),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .iss_ready (iss_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; wa = 5'd0; wd = 32'h0;
        iss_valid = 1'b0; iss_wa = 5'd0;
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    // Drives writes/issues throughout so the bench also sees them ignored.
    task automatic run_init(input int ncyc);
        we = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_wa = 5'd6; ra1 = 5'd5; ra2 = 5'd6;
        for (int i = 0; i < ncyc; i++) begin
            #1;
            chk($sformatf("init_done_low_c%0d", i), 32'(init_done), 32'd0);
            chk($sformatf("iss_ready_init_c%0d", i), 32'(iss_ready), 32'd0);
            chk($sformatf("rd1_init_c%0d", i), rd1, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic apply(input int i);
        ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
        iss_valid = vecs[i].iss_valid; iss_wa = vecs[i].iss_wa;
        we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
        #1;
        chk($sformatf("v%0d_rd1", i), rd1, vecs[i].e_rd1);
        chk($sformatf("v%0d_rd2", i), rd2, vecs[i].e_rd2);
        chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].e_b1));
        chk($sformatf("v%0d_busy2", i), 32'(busy2), 32'(vecs[i].e_b2));
        chk($sformatf("v%0d_iss_ready", i), 32'(iss_ready), 32'(vecs[i].e_rdy));
        @(negedge clk);
    endtask

    initial begin
        //            ra1    ra2    iv    iwa    we    wa     wd             e_rd1          e_rd2          b1    b2    rdy
        vecs[0]  = '{5'd1,  5'd2,  1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[1]  = '{5'd5,  5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  32'h12345678, 32'hDEADBEEF, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[2]  = '{5'd0,  5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{5'd7,  5'd0,  1'b1, 5'd7,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0,         1'b1, 1'b1, 1'b0};
        vecs[5]  = '{5'd5,  5'd8,  1'b0, 5'd8,  1'b1, 5'd7,  32'hA5,        32'hDEADBEEF, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[6]  = '{5'd7,  5'd5,  1'b0, 5'd7,  1'b0, 5'd0,  32'h0,         32'hA5,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{5'd3,  5'd7,  1'b1, 5'd9,  1'b1, 5'd9,  32'h55,        32'h0,         32'hA5,        1'b0, 1'b0, 1'b1};
        vecs[8]  = '{5'd9,  5'd9,  1'b0, 5'd9,  1'b0, 5'd0,  32'h0,         32'h55,        32'h55,        1'b1, 1'b1, 1'b0};
        vecs[9]  = '{5'd10, 5'd11, 1'b1, 5'd10, 1'b1, 5'd9,  32'h66,        32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[10] = '{5'd9,  5'd10, 1'b0, 5'd9,  1'b0, 5'd0,  32'h0,         32'h66,        32'h0,         1'b0, 1'b1, 1'b1};
        vecs[11] = '{5'd0,  5'd10, 1'b1, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 1'b1};
        vecs[12] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 5'd12, 32'h1234,      32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[13] = '{5'd12, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         32'h1234,      32'h0,         1'b0, 1'b0, 1'b1};
        vecs[14] = '{5'd12, 5'd0,  1'b0, 5'd0,  1'b1, 5'd3,  32'h77,        32'h1234,      32'h0,         1'b0, 1'b0, 1'b1};
        vecs[15] = '{5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 5'd0,  32'h0,         32'h77,        32'h0,         1'b0, 1'b0, 1'b1};
        vecs[16] = '{5'd3,  5'd0,  1'b0, 5'd3,  1'b0, 5'd0,  32'h0,         32'h77,        32'h0,         1'b1, 1'b0, 1'b0};
        vecs[17] = '{5'd3,  5'd12, 1'b0, 5'd0,  1'b1, 5'd4,  32'h44,        32'h77,        32'h1234,      1'b1, 1'b0, 1'b1};
        vecs[18] = '{5'd4,  5'd0,  1'b1, 5'd4,  1'b0, 5'd0,  32'h0,         32'h44,        32'h0,         1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_init_done", 32'(init_done), 32'd0);
        chk("reset_iss_ready", 32'(iss_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(32);
        idle();
        #1;
        chk("init_done_high", 32'(init_done), 32'd1);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1;
            chk($sformatf("zero_rd1_r%0d", a), rd1, 32'd0);
            chk($sformatf("zero_busy1_r%0d", a), 32'(busy1), 32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 19; i++) apply(i);

        // Read-during-write on reg 4 while it is pending.
        ra1 = 5'd4; ra2 = 5'd0; iss_valid = 1'b0; iss_wa = 5'd4;
        we = 1'b1; wa = 5'd4; wd = 32'h99;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("rdw_rd1", rd1, 32'h99);
        chk("rdw_busy1", 32'(busy1), 32'd0);
        chk("rdw_iss_ready", 32'(iss_ready), 32'd1);
`else
        chk("rdw_rd1", rd1, 32'h44);
        chk("rdw_busy1", 32'(busy1), 32'd1);
        chk("rdw_iss_ready", 32'(iss_ready), 32'd0);
`endif
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("rdw_after_rd1", rd1, 32'h99);
        chk("rdw_after_busy1", 32'(busy1), 32'd0);
        chk("rdw_after_iss_ready", 32'(iss_ready), 32'd1);
        @(negedge clk);

        // Reset with reg3 = 0x77 pending, then again 10 cycles into init.
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(10);
        rst_n = 1'b0;
        #1;
        chk("midinit_rst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(32);
        idle();
        ra1 = 5'd3; ra2 = 5'd4; iss_wa = 5'd3;
        #1;
        chk("reinit_done", 32'(init_done), 32'd1);
        chk("reinit_rd1_r3", rd1, 32'd0);
        chk("reinit_busy1_r3", 32'(busy1), 32'd0);
        chk("reinit_rd2_r4", rd2, 32'd0);
        chk("reinit_iss_ready_r3", 32'(iss_ready), 32'd1);
        ra1 = 5'd5; ra2 = 5'd6; iss_wa = 5'd6;
        #1;
        chk("reinit_rd1_r5", rd1, 32'd0);
        chk("reinit_busy2_r6", 32'(busy2), 32'd0);
        chk("reinit_iss_ready_r6", 32'(iss_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU integer register file: XLEN-wide, NREGS-deep, two async read ports, one write port.
- Adds an integrated pending-write scoreboard for the pipelined core.
- Adds a post-reset zeroing sequencer, so no register holds X after reset.
- Sits between decode/issue (reads, issue marking) and writeback (write, scoreboard clear).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; power of two, >=4
AW, $clog2(NREGS), address width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
init_done  out  1  high once zeroing sequence complete
ra1  in  AW  read address port 1
ra2  in  AW  read address port 2
rd1  out  XLEN  read data port 1
rd2  out  XLEN  read data port 2
busy1  out  1  pending-write bit of ra1
busy2  out  1  pending-write bit of ra2
iss_valid  in  1  issue request: mark iss_wa pending
iss_wa  in  AW  destination register of issuing instruction
iss_ready  out  1  issue may fire this cycle
we  in  1  writeback enable
wa  in  AW  writeback address
wd  in  XLEN  writeback data

Behaviour:
- States: INIT, RUN. The async rst_n assert, at any time including mid-sequence or mid-operation, forces:
  - state=INIT, init counter=0;
  - pending[]=0, init_done=0.
- Array contents are not reset by rst_n; the sequencer zeroes them.
- INIT:
  - Each clk writes 0 to regs[cnt], then cnt++.
  - When cnt==NREGS-1 is written, next state is RUN and init_done=1. Exactly NREGS cycles after rst_n deasserts.
  - we and iss_valid are ignored. iss_ready=0. rd1/rd2=0, busy1/busy2=0.
- RUN:
  - Reads are combinational: rd1=regs[ra1], rd2=regs[ra2], busyN=pending[raN].
  - Address 0 always reads 0 with busy 0.
- Write: if we && wa!=0, then regs[wa]<=wd and pending[wa]<=0 at the clk edge. A write with wa==0 is dropped.
- Issue:
  - iss_ready = init_done && (iss_wa==0 || !pending[iss_wa]). This is WAW protection; it is computed from the registered pending only.
  - Fire = iss_valid && iss_ready.
  - Fire with iss_wa!=0 sets pending[iss_wa] at the edge. Fire with iss_wa==0 is accepted and changes nothing.
- Writeback to a non-pending register is legal: data is written, pending stays 0.
- Same-cycle fire and we to the same register X: data is written, and pending[X] ends at 1 (set wins over clear).
- Same-cycle fire and we to different registers are independent.
- A read in the same cycle as a write to the same address returns the old value (no forwarding) unless the optional feature is enabled.
- No output is registered except init_done. Read latency is 0 cycles; write and pending updates are visible the cycle after the edge.

Optional Feature:
- Macro REGFILE_SB_BYPASS_EN.
- Defined: in RUN, if we && wa!=0 && wa==raN, then:
  - rdN=wd and busyN=0 in the same cycle (write-through forwarding);
  - iss_ready for iss_wa==wa also ignores the pending bit being cleared.
- Undefined: rdN returns the stored (old) value and busyN the registered pending bit until the next cycle; iss_ready uses registered pending only.

Test Plan:
- Reset/init: drop rst_n, release. Then:
  - init_done=0 and iss_ready=0 for exactly 32 clks;
  - init_done=1 on the 33rd;
  - every ra1 0..31 reads 0x00000000.
- Basic write/read: we=1, wa=5, wd=0xDEADBEEF. Next cycle ra1=5 gives rd1=0xDEADBEEF. Write wa=0, wd=0x12345678, then ra2=0 gives rd2=0.
- Scoreboard:
  - Issue iss_wa=7: next cycle busy1=1 with ra1=7, and iss_ready=0 for iss_wa=7.
  - Then we to wa=7, wd=0xA5: next cycle busy1=0, rd1=0xA5, iss_ready=1.
- Simultaneous set/clear: reg 9 not pending. Fire iss_wa=9 and we wa=9 wd=0x55 in the same cycle. Next cycle rd=0x55, busy=1.
- Reset mid-operation: pending[3]=1 and reg3=0x77. Assert rst_n at cycle 10 of init, then release. Required:
  - a full 32-cycle init restarts;
  - afterwards reg3=0, busy=0.
- Same-cycle read-during-write: we wa=4 wd=0x99 with ra1=4.
  - Without REGFILE_SB_BYPASS_EN: rd1=old value in that cycle.
  - With it defined: rd1=0x99 and busy1=0 in that cycle.
